// File: rtl/y86_pkg.sv
// Shared Y86-64 encodings for the SEQ control path: instruction codes,
// processor status, sequencer states and register-file selector constants.
package y86_pkg;

  localparam logic [3:0] I_HALT   = 4'h0;
  localparam logic [3:0] I_NOP    = 4'h1;
  localparam logic [3:0] I_RRMOVQ = 4'h2;
  localparam logic [3:0] I_IRMOVQ = 4'h3;
  localparam logic [3:0] I_RMMOVQ = 4'h4;
  localparam logic [3:0] I_MRMOVQ = 4'h5;
  localparam logic [3:0] I_OPQ    = 4'h6;
  localparam logic [3:0] I_JXX    = 4'h7;
  localparam logic [3:0] I_CALL   = 4'h8;
  localparam logic [3:0] I_RET    = 4'h9;
  localparam logic [3:0] I_PUSHQ  = 4'hA;
  localparam logic [3:0] I_POPQ   = 4'hB;

  localparam logic [3:0] REG_NONE = 4'hF;
  localparam logic [3:0] REG_RSP  = 4'h4;

  typedef enum logic [1:0] {
    STAT_AOK = 2'b00,
    STAT_HLT = 2'b01,
    STAT_ADR = 2'b10,
    STAT_INS = 2'b11
  } stat_e;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_FETCH     = 3'd1,
    ST_DECODE    = 3'd2,
    ST_EXECUTE   = 3'd3,
    ST_MEMORY    = 3'd4,
    ST_WRITEBACK = 3'd5,
    ST_PCUPD     = 3'd6,
    ST_HALTED    = 3'd7
  } state_e;

  function automatic logic is_mem_icode(input logic [3:0] ic);
    case (ic)
      I_RMMOVQ, I_MRMOVQ, I_CALL, I_RET, I_PUSHQ, I_POPQ: return 1'b1;
      default:                                            return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/seq_dst_sel.sv
// Register-file write selectors from latched instruction fields; shared
// between the stage sequencer and the decode block.
module seq_dst_sel
  import y86_pkg::*;
(
  input  logic [3:0] icode,
  input  logic [3:0] ra,
  input  logic [3:0] rb,
  input  logic       cnd_q,
  output logic [3:0] dst_e,
  output logic [3:0] dst_m
);

  always_comb begin
    dst_e = REG_NONE;
    dst_m = REG_NONE;
    case (icode)
      I_RRMOVQ:                       dst_e = cnd_q ? rb : REG_NONE;
      I_IRMOVQ, I_OPQ:                dst_e = rb;
      I_CALL, I_RET, I_PUSHQ, I_POPQ: dst_e = REG_RSP;
      default: ;
    endcase
    case (icode)
      I_MRMOVQ, I_POPQ: dst_m = ra;
      default: ;
    endcase
  end

endmodule

// File: rtl/seq_stage_ctrl.sv
// Y86-64 SEQ stage sequencer: one stage per cycle, MEMORY stretched until
// mem_ready (bounded by MEM_TIMEOUT), owns processor status and retire count.
module seq_stage_ctrl
  import y86_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 15
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        start,
  input  logic [3:0]  icode,
  input  logic [3:0]  ifun,
  input  logic [3:0]  ra,
  input  logic [3:0]  rb,
  input  logic        imem_error,
  input  logic        cnd,
  input  logic        mem_ready,
  input  logic        dmem_error,
  output logic [2:0]  stage,
  output logic        fetch_en,
  output logic        decode_en,
  output logic        exec_en,
  output logic        wb_en,
  output logic        pc_en,
  output logic        mem_req,
  output logic [3:0]  dst_e,
  output logic [3:0]  dst_m,
  output logic [1:0]  stat,
  output logic        busy,
  output logic [31:0] instr_count
);

  localparam int unsigned CW = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT + 1);
  localparam logic [CW-1:0] WAIT_LAST = CW'(MEM_TIMEOUT - 1);

  state_e        state_q, state_d;
  stat_e         stat_q, stat_d;
  logic [31:0]   count_q, count_d;
  logic [3:0]    icode_q, icode_d;
  logic [3:0]    ifun_q, ifun_d;
  logic [3:0]    ra_q, ra_d;
  logic [3:0]    rb_q, rb_d;
  logic          cnd_q, cnd_d;
  logic [CW-1:0] wait_q, wait_d;
  logic [3:0]    sel_e, sel_m;
  logic          unused_ifun;

  // ifun is latched with the other fields for the datapath but not decoded here
  assign unused_ifun = ^ifun_q;

  seq_dst_sel u_dst_sel (
    .icode (icode_q),
    .ra    (ra_q),
    .rb    (rb_q),
    .cnd_q (cnd_q),
    .dst_e (sel_e),
    .dst_m (sel_m)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      stat_q  <= STAT_AOK;
      count_q <= '0;
      icode_q <= '0;
      ifun_q  <= '0;
      ra_q    <= '0;
      rb_q    <= '0;
      cnd_q   <= 1'b0;
      wait_q  <= '0;
    end else begin
      state_q <= state_d;
      stat_q  <= stat_d;
      count_q <= count_d;
      icode_q <= icode_d;
      ifun_q  <= ifun_d;
      ra_q    <= ra_d;
      rb_q    <= rb_d;
      cnd_q   <= cnd_d;
      wait_q  <= wait_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    stat_d    = stat_q;
    count_d   = count_q;
    icode_d   = icode_q;
    ifun_d    = ifun_q;
    ra_d      = ra_q;
    rb_d      = rb_q;
    cnd_d     = cnd_q;
    wait_d    = wait_q;
    fetch_en  = 1'b0;
    decode_en = 1'b0;
    exec_en   = 1'b0;
    wb_en     = 1'b0;
    pc_en     = 1'b0;
    mem_req   = 1'b0;

    case (state_q)
      ST_IDLE, ST_HALTED: begin
        if (start) begin
          state_d = ST_FETCH;
          stat_d  = STAT_AOK;
        end
      end
      ST_FETCH: begin
        fetch_en = 1'b1;
        icode_d  = icode;
        ifun_d   = ifun;
        ra_d     = ra;
        rb_d     = rb;
        if (imem_error) begin
          stat_d  = STAT_ADR;
          state_d = ST_HALTED;
        end else if (icode > I_POPQ) begin
          stat_d  = STAT_INS;
          state_d = ST_HALTED;
        end else if (icode == I_HALT) begin
          stat_d  = STAT_HLT;
          count_d = count_q + 32'd1;
          state_d = ST_HALTED;
        end else begin
          state_d = ST_DECODE;
        end
      end
      ST_DECODE: begin
        decode_en = 1'b1;
        state_d   = ST_EXECUTE;
      end
      ST_EXECUTE: begin
        exec_en = 1'b1;
        cnd_d   = cnd;
        wait_d  = '0;
        state_d = ST_MEMORY;
      end
      ST_MEMORY: begin
        if (is_mem_icode(icode_q)) begin
          mem_req = 1'b1;
          if (mem_ready) begin
            if (dmem_error) begin
              stat_d  = STAT_ADR;
              state_d = ST_HALTED;
            end else begin
              state_d = ST_WRITEBACK;
            end
          end else if (wait_q == WAIT_LAST) begin
            // this is the MEM_TIMEOUT-th cycle without an acknowledge
            stat_d  = STAT_ADR;
            state_d = ST_HALTED;
          end else begin
            wait_d = wait_q + 1'b1;
          end
        end else begin
          state_d = ST_WRITEBACK;
        end
      end
      ST_WRITEBACK: begin
        wb_en   = 1'b1;
        state_d = ST_PCUPD;
      end
      ST_PCUPD: begin
        pc_en   = 1'b1;
        count_d = count_q + 32'd1;
        state_d = ST_FETCH;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    stage       = state_q;
    stat        = stat_q;
    instr_count = count_q;
    busy        = (state_q != ST_IDLE) && (state_q != ST_HALTED);
    dst_e       = (state_q == ST_WRITEBACK) ? sel_e : REG_NONE;
    dst_m       = (state_q == ST_WRITEBACK) ? sel_m : REG_NONE;
  end

endmodule

// File: tb/tb_seq_stage_ctrl.sv
// Scoreboard bench for seq_stage_ctrl: expected per-cycle stage records are
// queued with the stimulus; a negedge monitor pops one per busy cycle.
module tb_seq_stage_ctrl;
  import y86_pkg::*;

  logic        clock = 1'b0;
  logic        reset_n, start, imem_error, cnd, mem_ready, dmem_error;
  logic [3:0]  icode, ifun, ra, rb;
  logic [2:0]  stage;
  logic        fetch_en, decode_en, exec_en, wb_en, pc_en, mem_req, busy;
  logic [3:0]  dst_e, dst_m;
  logic [1:0]  stat;
  logic [31:0] instr_count;

  always #5 clock = ~clock;

  seq_stage_ctrl #(.MEM_TIMEOUT(15)) dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .start       (start),
    .icode       (icode),
    .ifun        (ifun),
    .ra          (ra),
    .rb          (rb),
    .imem_error  (imem_error),
    .cnd         (cnd),
    .mem_ready   (mem_ready),
    .dmem_error  (dmem_error),
    .stage       (stage),
    .fetch_en    (fetch_en),
    .decode_en   (decode_en),
    .exec_en     (exec_en),
    .wb_en       (wb_en),
    .pc_en       (pc_en),
    .mem_req     (mem_req),
    .dst_e       (dst_e),
    .dst_m       (dst_m),
    .stat        (stat),
    .busy        (busy),
    .instr_count (instr_count)
  );

  typedef struct packed {
    logic [2:0]  st;
    logic        mr;
    logic [3:0]  de;
    logic [3:0]  dm;
    logic [1:0]  stt;
    logic [31:0] cnt;
  } exp_t;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   n_rec   = 0;

  task automatic push(input logic [2:0] st, input logic mr, input logic [3:0] de,
                      input logic [3:0] dm, input logic [31:0] cnt);
    exp_t e;
    e.st = st; e.mr = mr; e.de = de; e.dm = dm; e.stt = STAT_AOK; e.cnt = cnt;
    sb.push_back(e);
  endtask

  // one instruction's cycle trace; full=0 stops after the MEMORY cycles
  task automatic push_instr(input logic mr, input int nmem, input logic [3:0] de,
                            input logic [3:0] dm, input logic [31:0] cnt, input logic full);
    push(ST_FETCH, 1'b0, 4'hF, 4'hF, cnt);
    push(ST_DECODE, 1'b0, 4'hF, 4'hF, cnt);
    push(ST_EXECUTE, 1'b0, 4'hF, 4'hF, cnt);
    for (int k = 0; k < nmem; k++) push(ST_MEMORY, mr, 4'hF, 4'hF, cnt);
    if (full) begin
      push(ST_WRITEBACK, 1'b0, de, dm, cnt);
      push(ST_PCUPD, 1'b0, 4'hF, 4'hF, cnt);
    end
  endtask

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic check_quiet(input string tag, input logic [2:0] st, input logic [1:0] stt,
                             input logic [31:0] cnt);
    check({tag, "-outs"},
          64'({stage, stat, busy, fetch_en, decode_en, exec_en, wb_en, pc_en, mem_req, dst_e, dst_m}),
          64'({st, stt, 1'b0, 5'b0, 1'b0, 4'hF, 4'hF}));
    check({tag, "-count"}, 64'(instr_count), 64'(cnt));
  endtask

  always @(negedge clock) begin
    exp_t e, a;
    logic [4:0] ee, ae;
    if (reset_n && busy) begin
      n_tests++;
      n_rec++;
      if (sb.size() == 0) begin
        n_fail++;
        $display("FAIL trace#%0d: unexpected busy cycle stage=%0d, none expected", n_rec, stage);
      end else begin
        e  = sb.pop_front();
        a  = {stage, mem_req, dst_e, dst_m, stat, instr_count};
        ee = {e.st == ST_FETCH, e.st == ST_DECODE, e.st == ST_EXECUTE,
              e.st == ST_WRITEBACK, e.st == ST_PCUPD};
        ae = {fetch_en, decode_en, exec_en, wb_en, pc_en};
        if (a !== e || ae !== ee) begin
          n_fail++;
          $display("FAIL trace#%0d: got st=%0d mr=%b de=%h dm=%h stat=%b cnt=%0d en=%b, expected st=%0d mr=%b de=%h dm=%h stat=%b cnt=%0d en=%b",
                   n_rec, a.st, a.mr, a.de, a.dm, a.stt, a.cnt, ae,
                   e.st, e.mr, e.de, e.dm, e.stt, e.cnt, ee);
        end
      end
    end
  end

  // called at a negedge whose following edge enters FETCH
  task automatic issue(input logic [3:0] ic, input logic [3:0] fn, input logic [3:0] a,
                       input logic [3:0] b, input logic c, input int nmem,
                       input logic rdy, input logic dmerr, input logic full);
    icode = ic; ifun = fn; ra = a; rb = b; cnd = c;
    @(negedge clock); start = 1'b0;
    @(negedge clock);
    @(negedge clock);
    for (int k = 1; k <= nmem; k++) begin
      @(negedge clock);
      mem_ready  = rdy && (k == nmem);
      dmem_error = dmerr;
    end
    @(negedge clock);
    mem_ready = 1'b0; dmem_error = 1'b0;
    if (full) @(negedge clock);
  endtask

  // single-cycle FETCH that ends in HALTED
  task automatic issue_fetch_only(input logic [3:0] ic, input logic imerr);
    icode = ic; imem_error = imerr;
    @(negedge clock); start = 1'b0;
    @(negedge clock); imem_error = 1'b0;
  endtask

  initial begin
    reset_n = 1'b0; start = 1'b0; imem_error = 1'b0; cnd = 1'b0;
    mem_ready = 1'b0; dmem_error = 1'b0;
    icode = '0; ifun = '0; ra = '0; rb = '0;
    repeat (2) @(negedge clock);
    check_quiet("reset", ST_IDLE, STAT_AOK, 32'd0);
    reset_n = 1'b1;
    @(negedge clock);
    check_quiet("idle-no-start", ST_IDLE, STAT_AOK, 32'd0);

    // program: opq, mrmovq (3 waits), cmov x2, rmmovq, pushq, popq, halt
    push_instr(1'b0, 1, 4'h3, 4'hF, 32'd0, 1'b1);
    push_instr(1'b1, 4, 4'hF, 4'h1, 32'd1, 1'b1);
    push_instr(1'b0, 1, 4'hF, 4'hF, 32'd2, 1'b1);
    push_instr(1'b0, 1, 4'h7, 4'hF, 32'd3, 1'b1);
    push_instr(1'b1, 1, 4'hF, 4'hF, 32'd4, 1'b1);
    push_instr(1'b1, 1, 4'h4, 4'hF, 32'd5, 1'b1);
    push_instr(1'b1, 2, 4'h4, 4'h3, 32'd6, 1'b1);
    push(ST_FETCH, 1'b0, 4'hF, 4'hF, 32'd7);
    start = 1'b1;
    issue(4'h6, 4'h0, 4'h2, 4'h3, 1'b0, 1, 1'b0, 1'b0, 1'b1);
    issue(4'h5, 4'h0, 4'h1, 4'h4, 1'b0, 4, 1'b1, 1'b0, 1'b1);
    issue(4'h2, 4'h1, 4'h5, 4'h7, 1'b0, 1, 1'b0, 1'b0, 1'b1);
    issue(4'h2, 4'h1, 4'h5, 4'h7, 1'b1, 1, 1'b0, 1'b0, 1'b1);
    issue(4'h4, 4'h0, 4'h2, 4'h3, 1'b0, 1, 1'b1, 1'b0, 1'b1);
    issue(4'hA, 4'h0, 4'h6, 4'hF, 1'b0, 1, 1'b1, 1'b0, 1'b1);
    issue(4'hB, 4'h0, 4'h3, 4'hF, 1'b0, 2, 1'b1, 1'b0, 1'b1);
    issue_fetch_only(4'h0, 1'b0);
    check_quiet("halt", ST_HALTED, STAT_HLT, 32'd8);

    // illegal icode, then restart with nop and halt again
    push(ST_FETCH, 1'b0, 4'hF, 4'hF, 32'd8);
    start = 1'b1;
    issue_fetch_only(4'hC, 1'b0);
    check_quiet("ins", ST_HALTED, STAT_INS, 32'd8);
    push_instr(1'b0, 1, 4'hF, 4'hF, 32'd8, 1'b1);
    push(ST_FETCH, 1'b0, 4'hF, 4'hF, 32'd9);
    start = 1'b1;
    issue(4'h1, 4'h0, 4'hF, 4'hF, 1'b0, 1, 1'b0, 1'b0, 1'b1);
    issue_fetch_only(4'h0, 1'b0);
    check_quiet("restart-halt", ST_HALTED, STAT_HLT, 32'd10);

    // data-memory fault on acknowledge in the second MEMORY cycle
    push_instr(1'b1, 2, 4'hF, 4'hF, 32'd10, 1'b0);
    start = 1'b1;
    issue(4'h5, 4'h0, 4'h1, 4'h2, 1'b0, 2, 1'b1, 1'b1, 1'b0);
    check_quiet("dmem-fault", ST_HALTED, STAT_ADR, 32'd10);

    // popq never acknowledged: 15 MEMORY cycles then ADR
    push_instr(1'b1, 15, 4'hF, 4'hF, 32'd10, 1'b0);
    start = 1'b1;
    issue(4'hB, 4'h0, 4'h3, 4'hF, 1'b0, 15, 1'b0, 1'b0, 1'b0);
    check_quiet("timeout", ST_HALTED, STAT_ADR, 32'd10);

    // fetch address fault
    push(ST_FETCH, 1'b0, 4'hF, 4'hF, 32'd10);
    start = 1'b1;
    issue_fetch_only(4'h6, 1'b1);
    check_quiet("imem-fault", ST_HALTED, STAT_ADR, 32'd10);

    // asynchronous reset in the middle of EXECUTE
    push(ST_FETCH, 1'b0, 4'hF, 4'hF, 32'd10);
    push(ST_DECODE, 1'b0, 4'hF, 4'hF, 32'd10);
    push(ST_EXECUTE, 1'b0, 4'hF, 4'hF, 32'd10);
    icode = 4'h6; ra = 4'h2; rb = 4'h3;
    start = 1'b1;
    @(negedge clock); start = 1'b0;
    @(negedge clock);
    @(negedge clock);
    #2 reset_n = 1'b0;
    #1 check_quiet("async-reset", ST_IDLE, STAT_AOK, 32'd0);
    @(negedge clock);
    reset_n = 1'b1;
    check("sb-drain", 64'(sb.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
